// File: rtl/shift_norm_pkg.sv
// Shared types and constants for the iterative 32-bit normalizer.
// Imported by the top level and by its single combinational stage.
package shift_norm_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic NORM_UNSIGNED = 1'b0;
  localparam logic NORM_SIGNED   = 1'b1;

  localparam logic [CNT_W-1:0] STAGE_SHIFT [0:4] = '{5'd16, 5'd8, 5'd4, 5'd2, 5'd1};

  // Stage indices 5..7 never occur in RUN; they map to a harmless zero shift.
  function automatic logic [CNT_W-1:0] stage_shift(input logic [2:0] idx);
    case (idx)
      3'd0:    return STAGE_SHIFT[0];
      3'd1:    return STAGE_SHIFT[1];
      3'd2:    return STAGE_SHIFT[2];
      3'd3:    return STAGE_SHIFT[3];
      3'd4:    return STAGE_SHIFT[4];
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/shift_normalizer_32_norm_stage.sv
// One binary-search step: decides whether the top bits of w are redundant
// for the current shift amount and, if so, returns w shifted left.
module norm_stage
  import shift_norm_pkg::*;
(
  input  logic [DATA_W-1:0] w_in,
  input  logic [CNT_W-1:0]  shamt,
  input  logic              mode,
  output logic [DATA_W-1:0] w_out,
  output logic              take
);

  logic [DATA_W-1:0] top_mask;
  logic [DATA_W-1:0] sign_mask;
  logic [DATA_W-1:0] sign_bits;

  // top_mask covers the upper shamt bits; sign_mask one more bit for the sign.
  assign top_mask  = ~({DATA_W{1'b1}} >> shamt);
  assign sign_mask = ~({DATA_W{1'b1}} >> ({1'b0, shamt} + 6'd1));
  assign sign_bits = w_in & sign_mask;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    take  = 1'b0;
    w_out = w_in;
    if (mode == NORM_SIGNED) begin
      take = (sign_bits == '0) || (sign_bits == sign_mask);
    end else begin
      take = ((w_in & top_mask) == '0);
    end
    if (take) begin
      w_out = w_in << shamt;
    end
  end

endmodule

// File: rtl/shift_normalizer_32.sv
// Iterative normalizer: 5-step binary search (16,8,4,2,1) yielding the left
// shift that normalizes an unsigned or signed operand, with start/done handshake.
module shift_normalizer_32
  import shift_norm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic              c,
  output logic [DATA_W-1:0] z,
  output logic [CNT_W-1:0]  b,
  output logic              zero,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic [2:0]        stage_idx;
  logic [DATA_W-1:0] w;
  logic [CNT_W-1:0]  cnt;
  logic              mode;
  logic              zero_pend;

  logic [CNT_W-1:0]  shamt;
  logic [DATA_W-1:0] w_next;
  logic              take;
  logic [CNT_W-1:0]  cnt_next;

  assign shamt    = stage_shift(stage_idx);
  assign cnt_next = cnt + (take ? shamt : '0);

  norm_stage u_stage (
    .w_in  (w),
    .shamt (shamt),
    .mode  (mode),
    .w_out (w_next),
    .take  (take)
  );

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the working register is reset too, so an aborted request leaves no trace.
      state     <= ST_IDLE;
      stage_idx <= '0;
      w         <= '0;
      cnt       <= '0;
      mode      <= NORM_UNSIGNED;
      zero_pend <= 1'b0;
      z         <= '0;
      b         <= '0;
      zero      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_RUN;
            stage_idx <= '0;
            w         <= a;
            cnt       <= '0;
            mode      <= c;
            zero_pend <= (a == '0);
            busy      <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          w         <= w_next;
          cnt       <= cnt_next;
          stage_idx <= stage_idx + 3'd1;
          // Results are published only on the edge that enters DONE.
          if (stage_idx == 3'd4) begin
            state <= ST_DONE;
            z     <= w_next;
            b     <= cnt_next;
            zero  <= zero_pend;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
